// File: rtl/lfm_pkg.sv
// Shared definitions for the linear-FM phase-increment generator.
//   lfm_state_e : controller states (IDLE, RUN)
//   ACC_W       : width of the Q(PHASE_W.FRAC_W) increment accumulator
//   freq2inc()  : converts a frequency step (Hz) at sample rate fs (Hz) into a
//                 rounded Q-format increment, for building chirp configurations
package lfm_pkg;

   localparam int LFM_PHASE_W = 16;
   localparam int LFM_FRAC_W  = 16;
   localparam int LFM_CNT_W   = 32;
   localparam int ACC_W       = LFM_PHASE_W + LFM_FRAC_W;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } lfm_state_e;

   // f_hz / fs_hz scaled by 2^ACC_W, rounded to nearest.
   function automatic logic [ACC_W-1:0] freq2inc(input longint unsigned f_hz,
                                                 input longint unsigned fs_hz);
      longint unsigned num;
      num = (f_hz << ACC_W) + (fs_hz >> 1);
      return ACC_W'(num / fs_hz);
   endfunction

endpackage

// File: rtl/lfm_phase_gen_if.sv
// AXI-Stream phase-increment channel (generator -> DDS S_AXIS_PHASE).
//   tdata  : phase increment, PHASE_W bits
//   tvalid : beat valid
//   tready : sink ready (tie high for a DDS without tready)
//   tlast  : last sample of a sweep
interface lfm_phase_gen_if #(
   parameter int PHASE_W = 16
) ();

   logic [PHASE_W-1:0] tdata;
   logic               tvalid;
   logic               tready;
   logic               tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/lfm_sweep_ctr.sv
// Sample/sweep counters for the chirp generator.
//   load_i        : start accepted; latches n_samples/n_sweeps, clears counters
//   run_i         : controller is in RUN (tvalid is high)
//   tready_i      : AXI-S ready, a beat is accepted when run_i && tready_i
//   stop_i        : abort request, held pending while a beat is stalled
//   tlast_o       : current beat is the last of its sweep
//   sweep_end_o   : the tlast beat is accepted this cycle
//   finish_o      : run terminates on this edge (all sweeps done or stop)
//   sweep_done_o  : registered pulse following sweep_end_o
//   done_o        : registered pulse following finish_o
module lfm_sweep_ctr
   import lfm_pkg::*;
#(
   parameter int CNT_W = LFM_CNT_W
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             load_i,
   input  logic             run_i,
   input  logic             tready_i,
   input  logic             stop_i,
   input  logic [CNT_W-1:0] n_samples_i,
   input  logic [CNT_W-1:0] n_sweeps_i,
   output logic             tlast_o,
   output logic             sweep_end_o,
   output logic             finish_o,
   output logic             sweep_done_o,
   output logic             done_o
);

   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic [CNT_W-1:0] n_samples_q, n_samples_d;
   logic [CNT_W-1:0] n_sweeps_q, n_sweeps_d;
   logic             stop_pend_q, stop_pend_d;
   logic             sweep_done_q, done_q;
   logic             last, beat, all_done, stop_now;

   always_comb begin
      last         = (sample_cnt_q == n_samples_q - CNT_W'(1));
      beat         = run_i && tready_i;
      tlast_o      = run_i && last;
      sweep_end_o  = beat && last;
      all_done     = sweep_end_o && (n_sweeps_q != '0) &&
                     (sweep_cnt_q + CNT_W'(1) == n_sweeps_q);
      // In RUN tvalid is always high, so "no stalled beat" means a beat is
      // being accepted: the stop lands on that beat's edge.
      stop_now     = beat && (stop_i || stop_pend_q);
      finish_o     = all_done || stop_now;

      sample_cnt_d = sample_cnt_q;
      sweep_cnt_d  = sweep_cnt_q;
      n_samples_d  = n_samples_q;
      n_sweeps_d   = n_sweeps_q;
      stop_pend_d  = stop_pend_q;

      if (load_i) begin
         sample_cnt_d = '0;
         sweep_cnt_d  = '0;
         n_samples_d  = n_samples_i;
         n_sweeps_d   = n_sweeps_i;
      end else if (beat) begin
         if (last) begin
            sample_cnt_d = '0;
            sweep_cnt_d  = sweep_cnt_q + CNT_W'(1);
         end else begin
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
         end
      end

      if (load_i || finish_o) begin
         stop_pend_d = 1'b0;
      end else if (run_i && stop_i) begin
         stop_pend_d = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sample_cnt_q <= '0;
         sweep_cnt_q  <= '0;
         n_samples_q  <= '0;
         n_sweeps_q   <= '0;
         stop_pend_q  <= 1'b0;
         sweep_done_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         sweep_cnt_q  <= sweep_cnt_d;
         n_samples_q  <= n_samples_d;
         n_sweeps_q   <= n_sweeps_d;
         stop_pend_q  <= stop_pend_d;
         sweep_done_q <= sweep_end_o;
         done_q       <= finish_o;
      end
   end

   assign sweep_done_o = sweep_done_q;
   assign done_o       = done_q;

endmodule

// File: rtl/lfm_phase_gen.sv
// Linear-FM chirp phase-increment generator feeding a DDS S_AXIS_PHASE port.
// A Q(PHASE_W.FRAC_W) accumulator adds the step each accepted beat so sub-LSB
// frequency steps accumulate exactly; tdata is the truncated integer part.
//   aclk, aresetn        : clock, async active-low reset
//   start, stop          : one-cycle control pulses
//   cfg_*                : sweep configuration, sampled on an accepted start
//   m_axis_phase         : AXI-S master (tdata/tvalid/tlast out, tready in)
//   busy                 : high in RUN
//   sweep_done, done     : end-of-sweep / end-of-run pulses
//   sweep_dir            : 1 = current sweep runs downward (LFM_TRIANGLE_EN only)
// Build option: define LFM_TRIANGLE_EN for triangular sweeps (odd sweeps run
// from start + (n_samples-1)*step back down to start).
//
// state | meaning
// IDLE  | no stream; waits for start with cfg_n_samples != 0
// RUN   | presenting beats; tvalid high
module lfm_phase_gen
   import lfm_pkg::*;
#(
   parameter int PHASE_W = LFM_PHASE_W,
   parameter int FRAC_W  = LFM_FRAC_W,
   parameter int CNT_W   = LFM_CNT_W
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       start,
   input  logic                       stop,
   input  logic [PHASE_W+FRAC_W-1:0]  cfg_start_inc,
   input  logic [PHASE_W+FRAC_W-1:0]  cfg_step_inc,
   input  logic [CNT_W-1:0]           cfg_n_samples,
   input  logic [CNT_W-1:0]           cfg_n_sweeps,
   lfm_phase_gen_if.master            m_axis_phase,
`ifdef LFM_TRIANGLE_EN
   output logic                       sweep_dir,
`endif
   output logic                       busy,
   output logic                       sweep_done,
   output logic                       done
);

   localparam int AW = PHASE_W + FRAC_W;

   lfm_state_e    state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] start_inc_q, start_inc_d;
   logic [AW-1:0] step_q, step_d;
   logic          load, beat, sweep_end, finish, tlast;

`ifdef LFM_TRIANGLE_EN
   logic          dir_q, dir_d;
   logic [AW-1:0] peak_q, peak_d;
   logic [AW-1:0] n_m1;
   logic [AW-1:0] span;

   // Modulo-2^AW product only needs the low AW bits of each operand.
   assign n_m1 = AW'(cfg_n_samples - CNT_W'(1));
   assign span = n_m1 * cfg_step_inc;
`endif

   assign load = (state_q == IDLE) && start && (cfg_n_samples != '0);
   assign beat = (state_q == RUN) && m_axis_phase.tready;

   lfm_sweep_ctr #(
      .CNT_W (CNT_W)
   ) u_sweep_ctr (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .load_i       (load),
      .run_i        (state_q == RUN),
      .tready_i     (m_axis_phase.tready),
      .stop_i       (stop),
      .n_samples_i  (cfg_n_samples),
      .n_sweeps_i   (cfg_n_sweeps),
      .tlast_o      (tlast),
      .sweep_end_o  (sweep_end),
      .finish_o     (finish),
      .sweep_done_o (sweep_done),
      .done_o       (done)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      start_inc_d = start_inc_q;
      step_d      = step_q;
`ifdef LFM_TRIANGLE_EN
      dir_d       = dir_q;
      peak_d      = peak_q;
`endif
      if (state_q == IDLE) begin
         if (load) begin
            state_d     = RUN;
            acc_d       = cfg_start_inc;
            start_inc_d = cfg_start_inc;
            step_d      = cfg_step_inc;
`ifdef LFM_TRIANGLE_EN
            dir_d       = 1'b0;
            peak_d      = cfg_start_inc + span;
`endif
         end
      end else begin
         if (beat) begin
`ifdef LFM_TRIANGLE_EN
            if (sweep_end) begin
               acc_d = dir_q ? start_inc_q : peak_q;
               dir_d = ~dir_q;
            end else begin
               acc_d = dir_q ? (acc_q - step_q) : (acc_q + step_q);
            end
`else
            acc_d = sweep_end ? start_inc_q : (acc_q + step_q);
`endif
         end
         if (finish) begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         start_inc_q <= '0;
         step_q      <= '0;
`ifdef LFM_TRIANGLE_EN
         dir_q       <= 1'b0;
         peak_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         start_inc_q <= start_inc_d;
         step_q      <= step_d;
`ifdef LFM_TRIANGLE_EN
         dir_q       <= dir_d;
         peak_q      <= peak_d;
`endif
      end
   end

   assign m_axis_phase.tvalid = (state_q == RUN);
   assign m_axis_phase.tdata  = acc_q[AW-1:FRAC_W];
   assign m_axis_phase.tlast  = tlast;
   assign busy                = (state_q == RUN);
`ifdef LFM_TRIANGLE_EN
   assign sweep_dir           = dir_q;
`endif

endmodule

// File: tb/tb_lfm_phase_gen.sv
// Self-checking bench for lfm_phase_gen. Expected beats come from a closed-form
// reference: sample k of sweep s is start + k*step (or peak - k*step on
// odd triangle sweeps), truncated to the top PHASE_W bits.
`timescale 1ns/1ps
module tb_lfm_phase_gen;
   import lfm_pkg::*;

   localparam int PW = 16;
   localparam int FW = 16;
   localparam int CW = 32;
   localparam int AW = PW + FW;
`ifdef LFM_TRIANGLE_EN
   localparam bit TRI = 1'b1;
`else
   localparam bit TRI = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [AW-1:0] cfg_start_inc = '0;
   logic [AW-1:0] cfg_step_inc = '0;
   logic [CW-1:0] cfg_n_samples = '0;
   logic [CW-1:0] cfg_n_sweeps = '0;
   logic          busy, sweep_done, done;
`ifdef LFM_TRIANGLE_EN
   logic          sweep_dir;
`endif

   lfm_phase_gen_if #(.PHASE_W(PW)) axis_if ();

   lfm_phase_gen #(.PHASE_W(PW), .FRAC_W(FW), .CNT_W(CW)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .start         (start),
      .stop          (stop),
      .cfg_start_inc (cfg_start_inc),
      .cfg_step_inc  (cfg_step_inc),
      .cfg_n_samples (cfg_n_samples),
      .cfg_n_sweeps  (cfg_n_sweeps),
      .m_axis_phase  (axis_if.master),
`ifdef LFM_TRIANGLE_EN
      .sweep_dir     (sweep_dir),
`endif
      .busy          (busy),
      .sweep_done    (sweep_done),
      .done          (done)
   );

   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit              m_run, m_pend, m_sd, m_done;
   longint unsigned m_k, m_s;
   logic [AW-1:0]   c_start, c_step;
   longint unsigned c_n, c_sw;

   // per-test statistics
   int              n_beats, n_tlast, n_sd, n_done;
   logic [PW-1:0]   beats_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] exp_tdata();
      logic [AW-1:0] off, peak, val;
      off  = AW'(m_k * c_step);
      peak = c_start + AW'((c_n - 1) * c_step);
      if (TRI && m_s[0]) val = peak - off;
      else               val = c_start + off;
      return val[AW-1:FW];
   endfunction

   // Advances the reference by one clock edge using the inputs now driven.
   task automatic model_edge();
      bit fin;
      m_sd   = 1'b0;
      m_done = 1'b0;
      if (!m_run) begin
         if (start && cfg_n_samples != 0) begin
            c_start = cfg_start_inc;
            c_step  = cfg_step_inc;
            c_n     = cfg_n_samples;
            c_sw    = cfg_n_sweeps;
            m_run   = 1'b1;
            m_k     = 0;
            m_s     = 0;
            m_pend  = 1'b0;
         end
      end else if (axis_if.tready) begin
         fin = stop || m_pend;
         if (m_k == c_n - 1) begin
            m_sd = 1'b1;
            m_k  = 0;
            m_s++;
            if (c_sw != 0 && m_s == c_sw) fin = 1'b1;
         end else begin
            m_k++;
         end
         if (fin) begin
            m_run  = 1'b0;
            m_done = 1'b1;
            m_pend = 1'b0;
         end
      end else if (stop) begin
         m_pend = 1'b1;
      end
   endtask

   task automatic check_outputs();
      check("tvalid", axis_if.tvalid, m_run);
      check("busy", busy, m_run);
      check("tlast", axis_if.tlast, m_run && (m_k == c_n - 1));
      check("sweep_done", sweep_done, m_sd);
      check("done", done, m_done);
      if (m_run) begin
         check("tdata", axis_if.tdata, exp_tdata());
`ifdef LFM_TRIANGLE_EN
         check("sweep_dir", sweep_dir, m_s[0]);
`endif
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, axis_if.tvalid, 1'b0);
      check({tag, "_tdata"}, axis_if.tdata, '0);
      check({tag, "_tlast"}, axis_if.tlast, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_sweep_done"}, sweep_done, 1'b0);
      check({tag, "_done"}, done, 1'b0);
   endtask

   // One clock: drive inputs, step the model, sample at the falling edge.
   task automatic cycle(input bit st, input bit sp, input bit rdy);
      start          = st;
      stop           = sp;
      axis_if.tready = rdy;
      if (axis_if.tvalid && rdy) begin
         n_beats++;
         if (axis_if.tlast) n_tlast++;
         beats_q.push_back(axis_if.tdata);
      end
      model_edge();
      @(negedge aclk);
      if (sweep_done) n_sd++;
      if (done) n_done++;
      check_outputs();
   endtask

   task automatic clear_stats();
      n_beats = 0; n_tlast = 0; n_sd = 0; n_done = 0;
      beats_q.delete();
   endtask

   task automatic set_cfg(input logic [AW-1:0] st, input logic [AW-1:0] sp,
                          input logic [CW-1:0] ns, input logic [CW-1:0] nw);
      cfg_start_inc = st; cfg_step_inc = sp; cfg_n_samples = ns; cfg_n_sweeps = nw;
   endtask

   // Stop with ready high, then let the run wind down.
   task automatic drain(input string tag);
      cycle(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
      check(tag, axis_if.tvalid, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      axis_if.tready = 1'b1;
      m_run = 0; m_pend = 0; m_sd = 0; m_done = 0; m_k = 0; m_s = 0;
      c_start = '0; c_step = '0; c_n = 1; c_sw = 0;
      clear_stats();

      repeat (3) @(negedge aclk);
      check_reset_outputs("rst_held");
      aresetn = 1'b1;
      @(negedge aclk);
      check_reset_outputs("rst_release");

      check("freq2inc_1k_100M", freq2inc(1000, 100_000_000), 32'h0000_A7C6);

      // start with n_samples == 0 is ignored
      clear_stats();
      set_cfg(32'h1234_0000, 32'h0001_0000, 0, 1);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (4) cycle(1'b0, 1'b0, 1'b1);
      check("nz_done_cnt", n_done, 0);

      // 0..10 MHz chirp at 100 MHz, two sweeps
      clear_stats();
      set_cfg('0, freq2inc(1000, 100_000_000), 10000, 2);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (20003) cycle(1'b0, 1'b0, 1'b1);
      check("chirp_beats", n_beats, 20000);
      check("chirp_tlast", n_tlast, 2);
      check("chirp_sweep_done", n_sd, 2);
      check("chirp_done", n_done, 1);
      check("chirp_s1", beats_q[1], 0);
      // 9999 * 0xA7C6 = 0x1998_FE9A, truncated -> 0x1998
      check("chirp_s9999", beats_q[9999], 16'h1998);
      check("chirp_s10000", beats_q[10000], 0);

      // backpressure, integer step
      clear_stats();
      set_cfg('0, 32'h0001_0000, 8, 1);
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 200 && m_run; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      check("bp_idle", axis_if.tvalid, 1'b0);
      check("bp_count", beats_q.size(), 8);
      foreach (beats_q[i]) check("bp_seq", beats_q[i], i);

      // stop while beat 6 is stalled
      clear_stats();
      set_cfg('0, 32'h0001_0000, 100, 0);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (6) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      check("stop_held", axis_if.tdata, 6);
      cycle(1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b1);
      check("stop_beats", n_beats, 7);
      check("stop_done", n_done, 1);
      check("stop_no_sweep_done", n_sd, 0);
      cycle(1'b0, 1'b1, 1'b1);   // stop in IDLE: no effect

      // continuous mode; start+stop together; config churn during RUN
      clear_stats();
      set_cfg($urandom, $urandom, 5, 0);
      cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 60; i++) begin
         set_cfg($urandom, $urandom, $urandom_range(0, 9), $urandom_range(0, 2));
         cycle(i == 10, 1'b0, $urandom_range(0, 3) != 0);
      end
      check("cont_gt3_sweeps", n_tlast > 3, 1'b1);
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 50 && m_run; i++) cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      check("cont_stopped", axis_if.tvalid, 1'b0);
      check("cont_done", n_done, 1);

      // downward-wrapping step
      clear_stats();
      set_cfg('0, 32'hFFFF_0000, 6, 1);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (8) cycle(1'b0, 1'b0, 1'b1);
      check("wrap_s1", beats_q[1], 16'hFFFF);
      check("wrap_s2", beats_q[2], 16'hFFFE);

      // randomized configurations, ready and stop
      for (int t = 0; t < 8; t++) begin
         clear_stats();
         set_cfg($urandom, $urandom, $urandom_range(1, 6), $urandom_range(0, 3));
         for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0)
               set_cfg($urandom, $urandom, $urandom_range(0, 6), $urandom_range(0, 3));
            cycle(i == 0 || $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0);
         end
         drain("rand_drain");
      end

      // reset mid-run
      clear_stats();
      set_cfg(32'h0100_0000, 32'h0001_0000, 50, 0);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (10) cycle(1'b0, 1'b0, 1'b1);
      start = 1'b0; stop = 1'b0;
      #2 aresetn = 1'b0;
      #1 check_reset_outputs("rst_async");
      m_run = 0; m_pend = 0; m_sd = 0; m_done = 0;
      @(negedge aclk);
      check_reset_outputs("rst_mid");
      @(negedge aclk);
      aresetn = 1'b1;
      clear_stats();
      set_cfg(32'h0005_0000, 32'h0002_0000, 3, 1);
      cycle(1'b1, 1'b0, 1'b1);
      repeat (5) cycle(1'b0, 1'b0, 1'b1);
      check("rst_restart_beats", n_beats, 3);
      check("rst_restart_first", beats_q[0], 16'h0005);
      check("rst_restart_done", n_done, 1);

`ifdef LFM_TRIANGLE_EN
      begin
         int tri_exp[8] = '{0, 1, 2, 3, 3, 2, 1, 0};
         clear_stats();
         set_cfg('0, 32'h0001_0000, 4, 2);
         cycle(1'b1, 1'b0, 1'b1);
         repeat (10) cycle(1'b0, 1'b0, 1'b1);
         check("tri_count", beats_q.size(), 8);
         foreach (tri_exp[i]) check("tri_seq", beats_q[i], tri_exp[i]);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
